// File: rtl/nv_nvdla_mcif_write_ig_arb_pkg.sv
// Shared constants and payload types for the MCIF write-ingress arbiter.
package nv_nvdla_mcif_write_ig_arb_pkg;

  localparam int unsigned WDMA_NUM  = 5;
  localparam int unsigned OS_CNT_W  = 9;
  localparam int unsigned AXI_LEN_W = 2;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LIMIT_W   = 8;
  localparam int unsigned CMP_W     = OS_CNT_W + 1;

  localparam int unsigned CLIENT_BDMA = 0;
  localparam int unsigned CLIENT_SDP  = 1;
  localparam int unsigned CLIENT_PDP  = 2;
  localparam int unsigned CLIENT_CDP  = 3;
  localparam int unsigned CLIENT_RBK  = 4;

  localparam int unsigned CQ_PD_ACK     = 0;
  localparam int unsigned CQ_PD_LEN_LSB = 1;
  localparam int unsigned CQ_PD_LEN_MSB = 2;
  localparam int unsigned CQ_PD_W       = AXI_LEN_W + 1;

  // Context-queue entry: len in [2:1], require_ack in [0]
  typedef struct packed {
    logic [AXI_LEN_W-1:0] len;
    logic                 ack;
  } cq_pd_t;

endpackage

// File: rtl/nv_nvdla_mcif_write_ig_arb_if.sv
// Client request, context-queue, AW and egress-completion signals of the write ingress.
interface nv_nvdla_mcif_write_ig_arb_if;
  import nv_nvdla_mcif_write_ig_arb_pkg::*;

  logic [WDMA_NUM-1:0]           wr_req_vld;
  logic [WDMA_NUM-1:0]           wr_req_rdy;
  logic [WDMA_NUM*AXI_LEN_W-1:0] wr_req_len;
  logic [WDMA_NUM-1:0]           wr_req_ack;
  logic [WDMA_NUM-1:0]           cq_wr_pvld;
  logic [WDMA_NUM-1:0]           cq_wr_prdy;
  logic [CQ_PD_W-1:0]            cq_wr_pd;
  logic                          aw_vld;
  logic                          aw_rdy;
  logic [IDX_W-1:0]              aw_id;
  logic [AXI_LEN_W-1:0]          aw_len;
  logic                          eg2ig_axi_vld;
  logic [AXI_LEN_W-1:0]          eg2ig_axi_len;

  modport master (
    input  wr_req_vld, wr_req_len, wr_req_ack, cq_wr_prdy, aw_rdy, eg2ig_axi_vld, eg2ig_axi_len,
    output wr_req_rdy, cq_wr_pvld, cq_wr_pd, aw_vld, aw_id, aw_len
  );

  modport slave (
    output wr_req_vld, wr_req_len, wr_req_ack, cq_wr_prdy, aw_rdy, eg2ig_axi_vld, eg2ig_axi_len,
    input  wr_req_rdy, cq_wr_pvld, cq_wr_pd, aw_vld, aw_id, aw_len
  );

endinterface

// File: rtl/nv_nvdla_mcif_write_ig_rr.sv
// Five-way round-robin picker: search begins one past the last granted client.
module nv_nvdla_mcif_write_ig_rr
  import nv_nvdla_mcif_write_ig_arb_pkg::*;
(
  input  logic [WDMA_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [WDMA_NUM-1:0] gnt_c,
  output logic [IDX_W-1:0]    idx_c,
  output logic                any_c
);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned k = 1; k <= WDMA_NUM; k++) begin
      cand = (32'(ptr_i) + k) % WDMA_NUM;
      if (!any_c && req_i[IDX_W'(cand)]) begin
        any_c               = 1'b1;
        idx_c               = IDX_W'(cand);
        gnt_c[IDX_W'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_mcif_write_ig_arb.sv
// Write-ingress arbiter: round-robin over write DMA clients onto one AW channel,
// pushing a context entry per command and bounding outstanding beats by credit.
module nv_nvdla_mcif_write_ig_arb
  import nv_nvdla_mcif_write_ig_arb_pkg::*;
(
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  nv_nvdla_mcif_write_ig_arb_if.master  bus,
  input  logic [LIMIT_W-1:0]            reg2dp_wr_os_cnt,
  output logic [OS_CNT_W-1:0]           dp2reg_wr_os_cnt
);

  logic                 aw_vld_q, aw_vld_d;
  logic [IDX_W-1:0]     aw_id_q, aw_id_d;
  logic [AXI_LEN_W-1:0] aw_len_q, aw_len_d;
  logic [OS_CNT_W-1:0]  os_cnt_q, os_cnt_d;
  logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;

  logic                 slot_free;
  logic [CMP_W-1:0]     limit_beats;
  logic [WDMA_NUM-1:0]  eligible;
  logic [WDMA_NUM-1:0]  req;
  logic [WDMA_NUM-1:0]  gnt;
  logic [IDX_W-1:0]     g_idx;
  logic                 g_any;
  logic [AXI_LEN_W-1:0] g_len;
  cq_pd_t               pd_c;

  assign slot_free   = !aw_vld_q || bus.aw_rdy;
  assign limit_beats = CMP_W'(reg2dp_wr_os_cnt) + CMP_W'(1);

  // Credit check uses the registered count, so freed beats apply next cycle
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < WDMA_NUM; i++) begin
      eligible[i] = bus.wr_req_vld[i] && bus.cq_wr_prdy[i] &&
                    ((CMP_W'(os_cnt_q) + CMP_W'(bus.wr_req_len[i*AXI_LEN_W +: AXI_LEN_W]) +
                      CMP_W'(1)) <= limit_beats);
    end
  end

  assign req = (slot_free && nvdla_core_rstn) ? eligible : '0;

  nv_nvdla_mcif_write_ig_rr u_rr (
    .req_i (req),
    .ptr_i (last_gnt_q),
    .gnt_c (gnt),
    .idx_c (g_idx),
    .any_c (g_any)
  );

  assign g_len = bus.wr_req_len[{g_idx, 1'b0} +: AXI_LEN_W];

  always_comb begin
    pd_c     = '0;
    pd_c.len = g_any ? g_len : '0;
    pd_c.ack = g_any && bus.wr_req_ack[g_idx];
  end

  assign bus.wr_req_rdy = gnt;
  assign bus.cq_wr_pvld = gnt;
  assign bus.cq_wr_pd   = pd_c;

  always_comb begin
    aw_vld_d   = aw_vld_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    last_gnt_d = last_gnt_q;
    os_cnt_d   = os_cnt_q
               + (g_any ? (OS_CNT_W'(g_len) + OS_CNT_W'(1)) : '0)
               - (bus.eg2ig_axi_vld ? (OS_CNT_W'(bus.eg2ig_axi_len) + OS_CNT_W'(1)) : '0);
    if (slot_free) begin
      aw_vld_d = g_any;
      if (g_any) begin
        aw_id_d    = g_idx;
        aw_len_d   = g_len;
        last_gnt_d = g_idx;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      aw_vld_q   <= 1'b0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      os_cnt_q   <= '0;
      last_gnt_q <= IDX_W'(CLIENT_RBK);
    end else begin
      aw_vld_q   <= aw_vld_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      os_cnt_q   <= os_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign bus.aw_vld       = aw_vld_q;
  assign bus.aw_id        = aw_id_q;
  assign bus.aw_len       = aw_len_q;
  assign dp2reg_wr_os_cnt = os_cnt_q;

  a_os_no_underflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    bus.eg2ig_axi_vld |-> (os_cnt_q >= (OS_CNT_W'(bus.eg2ig_axi_len) + OS_CNT_W'(1))));

  a_aw_stable: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (aw_vld_q && !bus.aw_rdy) |=> (aw_vld_q && $stable(aw_id_q) && $stable(aw_len_q)));

endmodule

// File: tb/tb_nv_nvdla_mcif_write_ig_arb.sv
// Directed bench for the MCIF write-ingress arbiter.
module tb_nv_nvdla_mcif_write_ig_arb;

  logic       clk;
  logic       rstn;
  logic [7:0] limit;
  logic [8:0] os;
  int         checks = 0;
  int         errors = 0;

  nv_nvdla_mcif_write_ig_arb_if bus ();

  nv_nvdla_mcif_write_ig_arb dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .bus              (bus),
    .reg2dp_wr_os_cnt (limit),
    .dp2reg_wr_os_cnt (os)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_req_vld    = '0;
    bus.wr_req_len    = '0;
    bus.wr_req_ack    = '0;
    bus.cq_wr_prdy    = '1;
    bus.aw_rdy        = 1'b1;
    bus.eg2ig_axi_vld = 1'b0;
    bus.eg2ig_axi_len = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    limit = 8'd255;
    rstn  = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    limit = 8'd255;
    rstn  = 1'b0;
    step();
    checks++; if (bus.aw_vld !== 1'b0) begin errors++; $display("FAIL reset_aw_vld got %b exp 0", bus.aw_vld); end
    checks++; if (bus.aw_id !== 3'd0) begin errors++; $display("FAIL reset_aw_id got %0d exp 0", bus.aw_id); end
    checks++; if (bus.aw_len !== 2'd0) begin errors++; $display("FAIL reset_aw_len got %0d exp 0", bus.aw_len); end
    checks++; if (os !== 9'd0) begin errors++; $display("FAIL reset_os got %0d exp 0", os); end
    checks++; if (bus.wr_req_rdy !== 5'b0 || bus.cq_wr_pvld !== 5'b0) begin errors++; $display("FAIL reset_rdy got %b/%b exp 0", bus.wr_req_rdy, bus.cq_wr_pvld); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    bus.wr_req_vld = 5'b00100;
    bus.wr_req_len = 10'b00_00_11_00_00;
    bus.wr_req_ack = 5'b00100;
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b00100) begin errors++; $display("FAIL single_rdy got %b exp 00100", bus.wr_req_rdy); end
    checks++; if (bus.cq_wr_pvld !== 5'b00100) begin errors++; $display("FAIL single_pvld got %b exp 00100", bus.cq_wr_pvld); end
    checks++; if (bus.cq_wr_pd !== 3'b111) begin errors++; $display("FAIL single_pd got %b exp 111", bus.cq_wr_pd); end
    step();
    idle_inputs();
    checks++; if (bus.aw_vld !== 1'b1 || bus.aw_id !== 3'd2 || bus.aw_len !== 2'd3) begin errors++; $display("FAIL single_aw got vld=%b id=%0d len=%0d exp 1/2/3", bus.aw_vld, bus.aw_id, bus.aw_len); end
    checks++; if (os !== 9'd4) begin errors++; $display("FAIL single_os got %0d exp 4", os); end
    step();
    checks++; if (bus.aw_vld !== 1'b0) begin errors++; $display("FAIL single_aw_drop got %b exp 0", bus.aw_vld); end
  endtask

  task automatic test_rr();
    logic [4:0] exp_rdy;
    do_reset();
    bus.wr_req_vld = 5'b11111;
    for (int k = 0; k < 10; k++) begin
      exp_rdy = 5'b00001 << (k % 5);
      #1;
      checks++; if (bus.wr_req_rdy !== exp_rdy) begin errors++; $display("FAIL rr_rdy[%0d] got %b exp %b", k, bus.wr_req_rdy, exp_rdy); end
      step();
      checks++; if (bus.aw_vld !== 1'b1 || bus.aw_id !== 3'(k % 5)) begin errors++; $display("FAIL rr_aw[%0d] got vld=%b id=%0d exp 1/%0d", k, bus.aw_vld, bus.aw_id, k % 5); end
    end
    bus.wr_req_vld = '0;
    checks++; if (os !== 9'd10) begin errors++; $display("FAIL rr_os got %0d exp 10", os); end
  endtask

  task automatic test_credit();
    do_reset();
    limit          = 8'd3;
    bus.wr_req_vld = 5'b00001;
    bus.wr_req_len = 10'b00_00_00_00_11;
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b00001) begin errors++; $display("FAIL credit_first got %b exp 00001", bus.wr_req_rdy); end
    step();
    bus.wr_req_vld = 5'b00010;
    bus.wr_req_len = '0;
    checks++; if (os !== 9'd4) begin errors++; $display("FAIL credit_os_full got %0d exp 4", os); end
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b0) begin errors++; $display("FAIL credit_block got %b exp 0", bus.wr_req_rdy); end
    step();
    checks++; if (bus.aw_vld !== 1'b0) begin errors++; $display("FAIL credit_aw_idle got %b exp 0", bus.aw_vld); end
    bus.eg2ig_axi_vld = 1'b1;
    bus.eg2ig_axi_len = 2'd3;
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b0) begin errors++; $display("FAIL credit_same_cycle got %b exp 0", bus.wr_req_rdy); end
    step();
    bus.eg2ig_axi_vld = 1'b0;
    checks++; if (os !== 9'd0) begin errors++; $display("FAIL credit_os_freed got %0d exp 0", os); end
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b00010) begin errors++; $display("FAIL credit_release got %b exp 00010", bus.wr_req_rdy); end
    step();
    bus.wr_req_vld = '0;
    checks++; if (bus.aw_id !== 3'd1 || os !== 9'd1) begin errors++; $display("FAIL credit_aw got id=%0d os=%0d exp 1/1", bus.aw_id, os); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.aw_rdy     = 1'b0;
    bus.wr_req_vld = 5'b01001;
    bus.wr_req_len = 10'b00_10_00_00_01;
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b00001) begin errors++; $display("FAIL bp_first got %b exp 00001", bus.wr_req_rdy); end
    step();
    bus.wr_req_vld = 5'b01000;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.wr_req_rdy !== 5'b0) begin errors++; $display("FAIL bp_hold_rdy[%0d] got %b exp 0", k, bus.wr_req_rdy); end
      checks++; if (bus.aw_vld !== 1'b1 || bus.aw_id !== 3'd0 || bus.aw_len !== 2'd1) begin errors++; $display("FAIL bp_hold_aw[%0d] got %b/%0d/%0d exp 1/0/1", k, bus.aw_vld, bus.aw_id, bus.aw_len); end
      step();
    end
    bus.aw_rdy = 1'b1;
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b01000) begin errors++; $display("FAIL bp_release got %b exp 01000", bus.wr_req_rdy); end
    step();
    bus.wr_req_vld = '0;
    checks++; if (bus.aw_id !== 3'd3 || bus.aw_len !== 2'd2 || os !== 9'd5) begin errors++; $display("FAIL bp_second got id=%0d len=%0d os=%0d exp 3/2/5", bus.aw_id, bus.aw_len, os); end
  endtask

  task automatic test_cq_full();
    do_reset();
    bus.cq_wr_prdy = 5'b11101;
    bus.wr_req_vld = 5'b01010;
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b01000) begin errors++; $display("FAIL cq_skip got %b exp 01000", bus.wr_req_rdy); end
    step();
    bus.wr_req_vld = 5'b00010;
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b0 || bus.aw_id !== 3'd3) begin errors++; $display("FAIL cq_wait got rdy=%b id=%0d exp 0/3", bus.wr_req_rdy, bus.aw_id); end
    bus.cq_wr_prdy = 5'b11111;
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b00010) begin errors++; $display("FAIL cq_return got %b exp 00010", bus.wr_req_rdy); end
    step();
    bus.wr_req_vld = '0;
    checks++; if (bus.aw_vld !== 1'b1 || bus.aw_id !== 3'd1) begin errors++; $display("FAIL cq_aw got %b/%0d exp 1/1", bus.aw_vld, bus.aw_id); end
  endtask

  task automatic test_net();
    do_reset();
    bus.wr_req_vld = 5'b00001;
    bus.wr_req_len = 10'b00_00_00_00_11;
    step();
    bus.wr_req_vld = 5'b00010;
    bus.wr_req_len = '0;
    step();
    bus.wr_req_vld    = 5'b00100;
    bus.wr_req_len    = 10'b00_00_01_00_00;
    bus.eg2ig_axi_vld = 1'b1;
    bus.eg2ig_axi_len = 2'd2;
    checks++; if (os !== 9'd5) begin errors++; $display("FAIL net_pre got %0d exp 5", os); end
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b00100) begin errors++; $display("FAIL net_grant got %b exp 00100", bus.wr_req_rdy); end
    step();
    idle_inputs();
    checks++; if (os !== 9'd4) begin errors++; $display("FAIL net_os got %0d exp 4", os); end
  endtask

  task automatic test_limit_max();
    do_reset();
    bus.wr_req_vld = 5'b11111;
    bus.wr_req_len = 10'h3ff;
    repeat (64) step();
    checks++; if (os !== 9'd256) begin errors++; $display("FAIL max_os got %0d exp 256", os); end
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b0) begin errors++; $display("FAIL max_block got %b exp 0", bus.wr_req_rdy); end
    step();
    checks++; if (bus.aw_vld !== 1'b0) begin errors++; $display("FAIL max_aw_idle got %b exp 0", bus.aw_vld); end
    bus.eg2ig_axi_vld = 1'b1;
    bus.eg2ig_axi_len = 2'd0;
    step();
    bus.eg2ig_axi_vld = 1'b0;
    bus.wr_req_len    = '0;
    checks++; if (os !== 9'd255) begin errors++; $display("FAIL max_os_free got %0d exp 255", os); end
    #1;
    checks++; if (bus.wr_req_rdy !== 5'b10000) begin errors++; $display("FAIL max_last_beat got %b exp 10000", bus.wr_req_rdy); end
    step();
    bus.wr_req_vld = '0;
    checks++; if (os !== 9'd256) begin errors++; $display("FAIL max_os_top got %0d exp 256", os); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.aw_rdy     = 1'b0;
    bus.wr_req_vld = 5'b11111;
    bus.wr_req_len = 10'h155;
    step();
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.aw_vld !== 1'b0 || bus.aw_id !== 3'd0 || bus.aw_len !== 2'd0) begin errors++; $display("FAIL mid_aw got %b/%0d/%0d exp 0/0/0", bus.aw_vld, bus.aw_id, bus.aw_len); end
    checks++; if (os !== 9'd0) begin errors++; $display("FAIL mid_os got %0d exp 0", os); end
    checks++; if (bus.wr_req_rdy !== 5'b0 || bus.cq_wr_pvld !== 5'b0) begin errors++; $display("FAIL mid_rdy got %b/%b exp 0", bus.wr_req_rdy, bus.cq_wr_pvld); end
    idle_inputs();
    step();
    rstn = 1'b1;
    step();
    checks++; if (bus.aw_vld !== 1'b0) begin errors++; $display("FAIL mid_after got %b exp 0", bus.aw_vld); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_credit();
    test_backpressure();
    test_cq_full();
    test_net();
    test_limit_max();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
